// File: rtl/umi_arbiter_pkg.sv
// Shared definitions for the UMI arbiter: run-time mode encodings.
package umi_arbiter_pkg;

    // umi_mode encodings
    localparam logic UMI_ARB_RR   = 1'b0;  // round-robin
    localparam logic UMI_ARB_PRIO = 1'b1;  // fixed priority, index 0 highest

endpackage

// File: rtl/umi_arbiter_pick.sv
// Combinational N-way rotating priority picker. Produces a one-hot grant
// and its encoded index. In round-robin mode the search starts one past ptr;
// in priority mode it starts at index 0.
module umi_arbiter_pick
    import umi_arbiter_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    localparam logic [PW:0] NUM = (PW+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW:0]    start;
    logic [PW:0]    k;
    logic [PW:0]    sum;
    logic           found;

    // Rotate the request vector so the search start lands at bit 0, take the
    // lowest set bit, then rotate the winning index back.
    always_comb begin
        start = '0;
        if (mode == UMI_ARB_RR) begin
            start = {1'b0, ptr} + 1'b1;
            if (start >= NUM) start = '0;
        end
        dbl   = {req, req};
        rot   = dbl[start +: N];
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                k     = (PW+1)'(i);
            end
        end
        sum = start + k;
        if (sum >= NUM) sum = sum - NUM;
        idx   = sum[PW-1:0];
        grant = '0;
        if (found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/umi_arbiter.sv
// Merges N UMI requesters onto one channel through a single registered
// output stage. One transaction per cycle, one cycle of latency.
module umi_arbiter
    import umi_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 64,
    parameter int unsigned CW = 32,
    parameter int unsigned DW = 256,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic          umi_clk,
    input  logic          umi_reset,
    input  logic          umi_mode,
    input  logic [N-1:0]  umi_mask,
    input  logic [N-1:0]  umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]  umi_in_ready,
    output logic          umi_out_valid,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    output logic [PW-1:0] umi_out_src,
    input  logic          umi_out_ready
);

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [PW-1:0] pick_idx;
    logic          load;
    logic          any_req;

    logic [PW-1:0] ptr_q;
    logic          valid_q;
    logic [PW-1:0] src_q;
    logic [CW-1:0] cmd_q,  cmd_d;
    logic [AW-1:0] dst_q,  dst_d;
    logic [AW-1:0] srca_q, srca_d;
    logic [DW-1:0] data_q, data_d;

    assign req     = umi_in_valid & ~umi_mask;
    assign any_req = |req;
    // Output register may take a new beat when empty or being drained.
    assign load    = ~valid_q | umi_out_ready;

    umi_arbiter_pick #(
        .N (N)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .mode  (umi_mode),
        .grant (grant),
        .idx   (pick_idx)
    );

    // Accept strobe: granted requester only, never during reset.
    always_comb begin
        umi_in_ready = '0;
        if (load && !umi_reset) umi_in_ready = grant;
    end

    // AND-OR payload mux on the one-hot grant.
    always_comb begin
        cmd_d  = '0;
        dst_d  = '0;
        srca_d = '0;
        data_d = '0;
        for (int i = 0; i < N; i++) begin
            cmd_d  = cmd_d  | (umi_in_cmd[i*CW +: CW]     & {CW{grant[i]}});
            dst_d  = dst_d  | (umi_in_dstaddr[i*AW +: AW] & {AW{grant[i]}});
            srca_d = srca_d | (umi_in_srcaddr[i*AW +: AW] & {AW{grant[i]}});
            data_d = data_d | (umi_in_data[i*DW +: DW]    & {DW{grant[i]}});
        end
    end

    // Output stage and round-robin pointer; payload holds when nothing is captured.
    always_ff @(posedge umi_clk) begin
        if (umi_reset) begin
            valid_q <= 1'b0;
            src_q   <= '0;
            cmd_q   <= '0;
            dst_q   <= '0;
            srca_q  <= '0;
            data_q  <= '0;
            ptr_q   <= PW'(N-1);
        end else if (load) begin
            valid_q <= any_req;
            if (any_req) begin
                src_q  <= pick_idx;
                cmd_q  <= cmd_d;
                dst_q  <= dst_d;
                srca_q <= srca_d;
                data_q <= data_d;
                if (umi_mode == UMI_ARB_RR) ptr_q <= pick_idx;
            end
        end
    end

    assign umi_out_valid   = valid_q;
    assign umi_out_src     = src_q;
    assign umi_out_cmd     = cmd_q;
    assign umi_out_dstaddr = dst_q;
    assign umi_out_srcaddr = srca_q;
    assign umi_out_data    = data_q;

endmodule

// File: tb/tb_umi_arbiter.sv
// Scoreboard bench for umi_arbiter: the driver applies directed vectors and
// pushes the hand-expected winner; a monitor checks every presented output.
module tb_umi_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int CW = 32;
    localparam int DW = 256;

    logic            umi_clk = 1'b0;
    logic            umi_reset;
    logic            umi_mode;
    logic [N-1:0]    umi_mask;
    logic [N-1:0]    umi_in_valid;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic [1:0]      umi_out_src;
    logic            umi_out_ready;

    int checks   = 0;
    int failures = 0;
    logic [15:0] vid = '0;

    typedef struct packed {
        logic [1:0]  src;
        logic [15:0] vid;
    } exp_t;
    exp_t exp_q[$];

    umi_arbiter #(
        .N  (N),
        .AW (AW),
        .CW (CW),
        .DW (DW)
    ) dut (
        .umi_clk         (umi_clk),
        .umi_reset       (umi_reset),
        .umi_mode        (umi_mode),
        .umi_mask        (umi_mask),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_src     (umi_out_src),
        .umi_out_ready   (umi_out_ready)
    );

    always #5 umi_clk = ~umi_clk;

    // Payload of requester i during vector v: unique per source and per cycle.
    function automatic logic [CW-1:0] cmd_of(input int i, input logic [15:0] v);
        logic [3:0] s = 4'(i);
        return {4'hC, s, 8'h5A, v};
    endfunction

    function automatic logic [AW-1:0] dst_of(input int i, input logic [15:0] v);
        return {32'hD000_0000 | 32'(i), 16'h0000, v};
    endfunction

    function automatic logic [AW-1:0] srca_of(input int i, input logic [15:0] v);
        return ~dst_of(i, v);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i, input logic [15:0] v);
        logic [31:0] w = cmd_of(i, v) ^ (32'(v) * 32'd3);
        return {8{w}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_payload();
        for (int i = 0; i < N; i++) begin
            umi_in_cmd[i*CW +: CW]     = cmd_of(i, vid);
            umi_in_dstaddr[i*AW +: AW] = dst_of(i, vid);
            umi_in_srcaddr[i*AW +: AW] = srca_of(i, vid);
            umi_in_data[i*DW +: DW]    = data_of(i, vid);
        end
    endtask

    // One cycle of stimulus; exp_ready is the hand-derived accept strobe and
    // exp_ov the registered valid visible during this cycle.
    task automatic step(input logic [3:0] valid, input logic [3:0] mask, input logic mode,
                        input logic oready, input logic [3:0] exp_ready, input logic exp_ov);
        exp_t e;
        @(posedge umi_clk);
        #1;
        vid           = vid + 16'd1;
        umi_in_valid  = valid;
        umi_mask      = mask;
        umi_mode      = mode;
        umi_out_ready = oready;
        drive_payload();
        #1;
        chk("in_ready", DW'(umi_in_ready), DW'(exp_ready));
        chk("out_valid", DW'(umi_out_valid), DW'(exp_ov));
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) begin
                e.src = 2'(i);
                e.vid = vid;
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: every presented output must match the head of the scoreboard;
    // the head is popped only when downstream consumes it.
    always @(negedge umi_clk) begin
        exp_t e;
        if (!umi_reset && umi_out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected: got src %0d expected no output (t=%0t)",
                         umi_out_src, $time);
            end else begin
                e = exp_q[0];
                chk("out_src",     DW'(umi_out_src),     DW'(e.src));
                chk("out_cmd",     DW'(umi_out_cmd),     DW'(cmd_of(int'(e.src), e.vid)));
                chk("out_dstaddr", DW'(umi_out_dstaddr), DW'(dst_of(int'(e.src), e.vid)));
                chk("out_srcaddr", DW'(umi_out_srcaddr), DW'(srca_of(int'(e.src), e.vid)));
                chk("out_data",    umi_out_data,         data_of(int'(e.src), e.vid));
                if (umi_out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        umi_reset      = 1'b1;
        umi_mode       = 1'b0;
        umi_mask       = '0;
        umi_in_valid   = 4'b1111;
        umi_out_ready  = 1'b1;
        umi_in_cmd     = '0;
        umi_in_dstaddr = '0;
        umi_in_srcaddr = '0;
        umi_in_data    = '0;
        drive_payload();
        repeat (2) @(posedge umi_clk);
        #1;
        chk("rst_in_ready",  DW'(umi_in_ready),  '0);
        chk("rst_out_valid", DW'(umi_out_valid), '0);
        chk("rst_out_src",   DW'(umi_out_src),   '0);
        chk("rst_out_cmd",   DW'(umi_out_cmd),   '0);
        umi_reset    = 1'b0;
        umi_in_valid = '0;

        // Round-robin, all valid: 0,1,2,3,0,1 back to back.
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1);

        // Fixed priority with 1 and 3 valid: 1 always wins; ptr stays at 1.
        step(4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1);
        step(4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1);
        step(4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1);
        // Back to round-robin: 3,1,3.
        step(4'b1010, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1);
        step(4'b1010, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1);
        step(4'b1010, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1);

        // Stall for 5 cycles holding requester 0, then release: next is 1.
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1);
        repeat (5) step(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1);

        // Mask 0 and 2: 3,1,3; stall; unmask mid-stall; release picks 0.
        step(4'b1111, 4'b0101, 1'b0, 1'b1, 4'b1000, 1'b1);
        step(4'b1111, 4'b0101, 1'b0, 1'b1, 4'b0010, 1'b1);
        step(4'b1111, 4'b0101, 1'b0, 1'b1, 4'b1000, 1'b1);
        step(4'b1111, 4'b0101, 1'b0, 1'b0, 4'b0000, 1'b1);
        step(4'b1111, 4'b0101, 1'b0, 1'b0, 4'b0000, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1);

        // Requester 2 toggling: valid follows with one cycle of lag.
        step(4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);

        // Reset while holding a stalled output: the held beat is dropped.
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        @(posedge umi_clk);
        #1;
        umi_reset = 1'b1;
        vid       = vid + 16'd1;
        drive_payload();
        #1;
        chk("rstmid_in_ready", DW'(umi_in_ready), '0);
        @(posedge umi_clk);
        #1;
        exp_q.delete();
        chk("rstmid_out_valid", DW'(umi_out_valid), '0);
        chk("rstmid_out_src",   DW'(umi_out_src),   '0);
        umi_reset    = 1'b0;
        umi_in_valid = '0;
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);

        repeat (2) @(posedge umi_clk);
        #1;
        chk("scoreboard_drained", DW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
